fmap_stream_buf: RTL

//   Frame buffer between network layers. Receives one complete feature-map frame from a conv stage
//   (CHANNEL*N-bit pixels, raster order, vld/end handshake) and stores it.
//   On start, replays the frame downstream as an input_vld/input_din-style pixel stream.

---
 rtl/nn_pkg.sv | 25 ++
 rtl/fmap_ram.sv | 23 ++
 rtl/fmap_stream_buf.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and elaboration helpers for the feature-map buffering blocks.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_READY,
    ST_DRAIN
  } state_t;

  // Never returns less than 1 so degenerate sizes still produce a legal vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int depth_of(input int size);
    return size * size;
  endfunction

endpackage

// File: rtl/fmap_ram.sv
// Simple dual-port frame store: one write port, one synchronous read port, no reset on contents.
module fmap_ram #(
  parameter int DEPTH  = 36,
  parameter int W      = 48,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [W-1:0]      rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fmap_stream_buf.sv
// Captures one raster feature-map frame, then replays it as a pixel stream on start.
// Replay latency is two cycles from the start edge; optional idle gap after each row.
module fmap_stream_buf
  import nn_pkg::*;
#(
  parameter int N       = 16,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 6,
  parameter int ROW_GAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  input  logic                 input_end,
  input  logic                 start,
  output logic                 buf_full,
  output logic                 busy,
  output logic [CHANNEL*N-1:0] stream_dout,
  output logic                 stream_dout_vld,
  output logic                 stream_dout_end,
  output logic                 err_overflow,
  output logic                 err_frame
);

  localparam int W      = CHANNEL * N;
  localparam int DEPTH  = depth_of(SIZE);
  localparam int ADDR_W = clog2(DEPTH);
  localparam int GAP_W  = clog2(ROW_GAP + 1);
  localparam int COL_W  = clog2(SIZE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              rd_done;
  logic              rd_vld_q;
  logic              rd_last_q;
  logic [W-1:0]      rd_data;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_last;
  logic              rd_en;

  assign wr_en   = input_vld && (state == ST_IDLE || state == ST_FILL);
  assign wr_addr = (state == ST_FILL) ? wr_cnt : '0;
  assign wr_last = (wr_addr == LAST);
  assign rd_en   = (state == ST_DRAIN) && !rd_done && (gap_cnt == '0);

  fmap_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(input_din),
    .rd_en  (rd_en),
    .rd_addr(rd_cnt),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      wr_cnt          <= '0;
      rd_cnt          <= '0;
      col_cnt         <= '0;
      gap_cnt         <= '0;
      rd_done         <= 1'b0;
      rd_vld_q        <= 1'b0;
      rd_last_q       <= 1'b0;
      buf_full        <= 1'b0;
      busy            <= 1'b0;
      stream_dout     <= '0;
      stream_dout_vld <= 1'b0;
      stream_dout_end <= 1'b0;
      err_overflow    <= 1'b0;
      err_frame       <= 1'b0;
    end else begin
      // Output stage sits one cycle behind the RAM read register.
      rd_vld_q        <= rd_en;
      rd_last_q       <= rd_en && (rd_cnt == LAST);
      stream_dout_vld <= rd_vld_q;
      stream_dout_end <= rd_last_q;
      if (rd_vld_q) stream_dout <= rd_data;

      if (input_vld && (state == ST_READY || state == ST_DRAIN)) err_overflow <= 1'b1;
      if (wr_en && (input_end != wr_last)) err_frame <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (input_vld) begin
            if (wr_last) begin
              state    <= ST_READY;
              buf_full <= 1'b1;
            end else begin
              state  <= ST_FILL;
              busy   <= 1'b1;
              wr_cnt <= ADDR_W'(1);
            end
          end
        end
        ST_FILL: begin
          if (input_vld) begin
            if (wr_last) begin
              state    <= ST_READY;
              busy     <= 1'b0;
              buf_full <= 1'b1;
              wr_cnt   <= '0;
            end else begin
              wr_cnt <= wr_cnt + ADDR_W'(1);
            end
          end
        end
        ST_READY: begin
          if (start) begin
            state    <= ST_DRAIN;
            buf_full <= 1'b0;
            busy     <= 1'b1;
            rd_cnt   <= '0;
            col_cnt  <= '0;
            gap_cnt  <= '0;
            rd_done  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (rd_en) begin
            if (rd_cnt == LAST) begin
              rd_done <= 1'b1;
            end else begin
              rd_cnt <= rd_cnt + ADDR_W'(1);
              if (col_cnt == COL_W'(SIZE - 1)) begin
                col_cnt <= '0;
                gap_cnt <= GAP_W'(ROW_GAP);
              end else begin
                col_cnt <= col_cnt + COL_W'(1);
              end
            end
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
          // Leave one cycle after the final pixel has been presented.
          if (stream_dout_end) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
